// File: rtl/vm2002_common_pkg.sv
// vm2002_common_pkg: shared coin types, change FSM states and coin values for the vm2002.
package vm2002_common_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        NICKEL    = 2'd1,
        DIME      = 2'd2,
        QUARTER   = 2'd3
    } coins_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        REQ    = 2'd2,
        DONE   = 2'd3
    } change_state_t;

    localparam logic [7:0] NICKEL_CENTS  = 8'd5;
    localparam logic [7:0] DIME_CENTS    = 8'd10;
    localparam logic [7:0] QUARTER_CENTS = 8'd25;

    function automatic logic [7:0] coin_value(input coins_t c);
        return (c == QUARTER) ? QUARTER_CENTS :
               (c == DIME)    ? DIME_CENTS    :
               (c == NICKEL)  ? NICKEL_CENTS  : 8'd0;
    endfunction

endpackage

// File: rtl/vm2002_coin_tube.sv
// vm2002_coin_tube: one hopper tube inventory with saturating refill and dispense decrement.
module vm2002_coin_tube #(
    parameter int COUNT_W = 6
) (
    input  logic               clk,
    input  logic               hrst,
    input  logic               load_en,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               dec_en,
    output logic [COUNT_W-1:0] count,
    output logic               nonzero
);

    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W:0]   sum;

    assign sum = {1'b0, cnt_q} + {1'b0, load_count};

    always_comb begin
        cnt_d = load_en ? (sum[COUNT_W] ? '1 : sum[COUNT_W-1:0]) :
                (dec_en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (hrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign nonzero = cnt_q != '0;

endmodule

// File: rtl/vm2002_change_ctrl.sv
// vm2002_change_ctrl: pays out a cents balance one coin at a time over a hopper req/ack
// handshake, greedy largest-coin-first with fallback, tracking tube inventories.
module vm2002_change_ctrl
    import vm2002_common_pkg::*;
#(
    parameter int COUNT_W     = 6,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               hrst,
    input  logic               start,
    input  logic [7:0]         balance,
    input  logic               load_valid,
    input  logic [1:0]         load_coin,
    input  logic [COUNT_W-1:0] load_count,
    output logic               load_ready,
    output logic               busy,
    output logic               disp_req,
    output logic [1:0]         disp_coin,
    input  logic               hopper_ack,
    output logic               done,
    output logic               short,
    output logic               fault,
    output logic [7:0]         remaining,
    output logic [COUNT_W-1:0] inv_nickel,
    output logic [COUNT_W-1:0] inv_dime,
    output logic [COUNT_W-1:0] inv_quarter
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    change_state_t    state_q, state_d;
    coins_t           coin_q, coin_d, pick, lc;
    logic [7:0]       rem_q, rem_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             req_q, done_q, short_q, short_d, fault_q, fault_d, busy_q, lr_q;
    logic             nz_n, nz_d, nz_q, load_acc, ack_acc;

    assign lc       = coins_t'(load_coin);
    assign load_acc = load_valid && lr_q;
    assign ack_acc  = state_q == REQ && hopper_ack;

    assign pick = (rem_q >= QUARTER_CENTS && nz_q) ? QUARTER :
                  (rem_q >= DIME_CENTS    && nz_d) ? DIME    :
                  (rem_q >= NICKEL_CENTS  && nz_n) ? NICKEL  : COIN_NONE;

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        short_d = short_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = balance;
                    short_d = 1'b0;
                    fault_d = 1'b0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (pick != COIN_NONE) begin
                    coin_d  = pick;
                    tmo_d   = '0;
                    state_d = REQ;
                end else begin
                    short_d = rem_q != 8'd0;
                    state_d = DONE;
                end
            end
            REQ: begin
                if (hopper_ack) begin
                    rem_d   = rem_q - coin_value(coin_q);
                    state_d = SELECT;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    fault_d = 1'b1;
                    short_d = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered off the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (hrst) begin
            state_q <= IDLE;
            coin_q  <= COIN_NONE;
            rem_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            lr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            req_q   <= state_d == REQ;
            done_q  <= state_d == DONE;
            short_q <= short_d;
            fault_q <= fault_d;
            busy_q  <= state_d != IDLE;
            lr_q    <= state_d == IDLE;
        end
    end

    vm2002_coin_tube #(.COUNT_W(COUNT_W)) u_tube_n (
        .clk       (clk),
        .hrst      (hrst),
        .load_en   (load_acc && lc == NICKEL),
        .load_count(load_count),
        .dec_en    (ack_acc && coin_q == NICKEL),
        .count     (inv_nickel),
        .nonzero   (nz_n)
    );

    vm2002_coin_tube #(.COUNT_W(COUNT_W)) u_tube_d (
        .clk       (clk),
        .hrst      (hrst),
        .load_en   (load_acc && lc == DIME),
        .load_count(load_count),
        .dec_en    (ack_acc && coin_q == DIME),
        .count     (inv_dime),
        .nonzero   (nz_d)
    );

    vm2002_coin_tube #(.COUNT_W(COUNT_W)) u_tube_q (
        .clk       (clk),
        .hrst      (hrst),
        .load_en   (load_acc && lc == QUARTER),
        .load_count(load_count),
        .dec_en    (ack_acc && coin_q == QUARTER),
        .count     (inv_quarter),
        .nonzero   (nz_q)
    );

    assign load_ready = lr_q;
    assign busy       = busy_q;
    assign disp_req   = req_q;
    assign disp_coin  = coin_q;
    assign done       = done_q;
    assign short      = short_q;
    assign fault      = fault_q;
    assign remaining  = rem_q;

endmodule

// File: tb/tb_vm2002_change_ctrl.sv
// tb_vm2002_change_ctrl: scoreboard bench; stimulus queues expected coins/done results, a monitor pops them.
module tb_vm2002_change_ctrl;

    logic       clk = 1'b0;
    logic       hrst = 1'b1, start = 1'b0, load_valid = 1'b0, hopper_ack = 1'b0, ack_en = 1'b1;
    logic [7:0] balance = 8'd0;
    logic [1:0] load_coin = 2'd0;
    logic [5:0] load_count = 6'd0;
    logic       load_ready, busy, disp_req, done, short, fault;
    logic [1:0] disp_coin;
    logic [7:0] remaining;
    logic [5:0] inv_nickel, inv_dime, inv_quarter;

    always #5 clk = ~clk;

    vm2002_change_ctrl #(.COUNT_W(6), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .hrst(hrst), .start(start), .balance(balance),
        .load_valid(load_valid), .load_coin(load_coin), .load_count(load_count),
        .load_ready(load_ready), .busy(busy), .disp_req(disp_req), .disp_coin(disp_coin),
        .hopper_ack(hopper_ack), .done(done), .short(short), .fault(fault),
        .remaining(remaining), .inv_nickel(inv_nickel), .inv_dime(inv_dime),
        .inv_quarter(inv_quarter)
    );

    typedef struct {
        bit         is_done;
        logic [1:0] coin;
        bit         sh;
        bit         ft;
        logic [7:0] rem;
        logic [5:0] q, d, n;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0, errors = 0;
    bit   req_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic exp_coin(input logic [1:0] c);
        exp_t e;
        e = '{is_done: 1'b0, coin: c, sh: 1'b0, ft: 1'b0, rem: 8'd0, q: 6'd0, d: 6'd0, n: 6'd0};
        sb.push_back(e);
    endtask

    task automatic exp_done(input bit sh, input bit ft, input logic [7:0] rem,
                            input logic [5:0] q, input logic [5:0] d, input logic [5:0] n);
        exp_t e;
        e = '{is_done: 1'b1, coin: 2'd0, sh: sh, ft: ft, rem: rem, q: q, d: d, n: n};
        sb.push_back(e);
    endtask

    // Monitor: a new request and each done pulse consume one scoreboard entry; also models the hopper.
    always @(negedge clk) begin
        if (disp_req === 1'b1 && !req_prev) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req actual_coin=%0d required=none", disp_coin);
            end else begin
                me = sb.pop_front();
                chk("req_kind", {31'd0, me.is_done}, 32'd0);
                chk("disp_coin", {30'd0, disp_coin}, {30'd0, me.coin});
            end
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                me = sb.pop_front();
                chk("done_kind", {31'd0, me.is_done}, 32'd1);
                chk("short", {31'd0, short}, {31'd0, me.sh});
                chk("fault", {31'd0, fault}, {31'd0, me.ft});
                chk("remaining", {24'd0, remaining}, {24'd0, me.rem});
                chk("inv_quarter", {26'd0, inv_quarter}, {26'd0, me.q});
                chk("inv_dime", {26'd0, inv_dime}, {26'd0, me.d});
                chk("inv_nickel", {26'd0, inv_nickel}, {26'd0, me.n});
            end
        end
        req_prev   = disp_req === 1'b1;
        hopper_ack = ack_en && disp_req === 1'b1 && !hopper_ack;
    end

    task automatic refill(input logic [1:0] c, input logic [5:0] n);
        @(negedge clk);
        load_valid = 1'b1; load_coin = c; load_count = n;
        @(negedge clk);
        load_valid = 1'b0; load_coin = 2'd0; load_count = 6'd0;
    endtask

    task automatic do_start(input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; balance = b;
        @(negedge clk);
        start = 1'b0; balance = 8'd0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk(nm, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_reset();
        hrst = 1'b1;
        repeat (2) @(negedge clk);
        hrst = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_disp_req", {31'd0, disp_req}, 32'd0);
        chk("rst_disp_coin", {30'd0, disp_coin}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_short_fault", {30'd0, short, fault}, 32'd0);
        chk("rst_remaining", {24'd0, remaining}, 32'd0);
        chk("rst_inv", {14'd0, inv_quarter, inv_dime, inv_nickel}, 32'd0);
        hrst = 1'b0;

        // 65 cents from four of each: Q Q D N
        refill(2'd3, 6'd4); refill(2'd2, 6'd4); refill(2'd1, 6'd4);
        exp_coin(2'd3); exp_coin(2'd3); exp_coin(2'd2); exp_coin(2'd1);
        exp_done(1'b0, 1'b0, 8'd0, 6'd2, 6'd3, 6'd3);
        do_start(8'd65);
        wait_done("t1_done_seen");

        // 40 cents with Q=1 D=0 N=2: Q N N, 5 short
        pulse_reset();
        refill(2'd3, 6'd1); refill(2'd1, 6'd2);
        exp_coin(2'd3); exp_coin(2'd1); exp_coin(2'd1);
        exp_done(1'b1, 1'b0, 8'd5, 6'd0, 6'd0, 6'd0);
        do_start(8'd40);
        wait_done("t2_done_seen");

        // zero balance: done two cycles after start, no request
        exp_done(1'b0, 1'b0, 8'd0, 6'd0, 6'd0, 6'd0);
        do_start(8'd0);
        @(negedge clk);
        chk("t3_zero_done_latency", {31'd0, done}, 32'd1);
        chk("t3_zero_no_req", {31'd0, disp_req}, 32'd0);

        // 7 cents: one nickel, 2 cents residue
        refill(2'd1, 6'd5);
        exp_coin(2'd1);
        exp_done(1'b1, 1'b0, 8'd2, 6'd0, 6'd0, 6'd4);
        do_start(8'd7);
        @(negedge clk);
        chk("t3_first_req_latency", {31'd0, disp_req}, 32'd1);
        wait_done("t3_done_seen");

        // no ack: request held 16 cycles, then fault with inventory untouched
        refill(2'd3, 6'd1);
        ack_en = 1'b0;
        exp_coin(2'd3);
        exp_done(1'b1, 1'b1, 8'd25, 6'd1, 6'd0, 6'd4);
        do_start(8'd25);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (disp_req === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        chk("t4_req_cycles", cnt, 32'd16);
        wait_done("t4_done_seen");

        // start and refill during a payout are both ignored
        exp_coin(2'd1);
        exp_done(1'b1, 1'b1, 8'd5, 6'd1, 6'd0, 6'd4);
        do_start(8'd5);
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_load_ready_low", {31'd0, load_ready}, 32'd0);
        start = 1'b1; balance = 8'd200;
        load_valid = 1'b1; load_coin = 2'd1; load_count = 6'd10;
        @(negedge clk);
        start = 1'b0; balance = 8'd0;
        load_valid = 1'b0; load_coin = 2'd0; load_count = 6'd0;
        chk("t5_remaining_kept", {24'd0, remaining}, 32'd5);
        wait_done("t5_done_seen");
        ack_en = 1'b1;
        refill(2'd1, 6'd60);
        chk("t5_sat_first", {26'd0, inv_nickel}, 32'd63);
        refill(2'd1, 6'd10);
        chk("t5_sat_second", {26'd0, inv_nickel}, 32'd63);
        refill(2'd0, 6'd5);
        chk("t5_none_ignored", {14'd0, inv_quarter, inv_dime, inv_nickel}, {14'd0, 6'd1, 6'd0, 6'd63});

        // hard reset mid-request aborts without done
        ack_en = 1'b0;
        exp_coin(2'd3);
        do_start(8'd25);
        @(negedge clk);
        chk("t6_req_before_rst", {31'd0, disp_req}, 32'd1);
        #1 hrst = 1'b1;
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_disp_req", {31'd0, disp_req}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_inv", {14'd0, inv_quarter, inv_dime, inv_nickel}, 32'd0);
        hrst = 1'b0;
        ack_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vm2002_change_ctrl.md
Name: vm2002_change_ctrl

Overview:
Change-dispense sequencer for the vm2002 vending machine.
- After a vend or a cancel, the main FSM hands over the balance in cents. This block pays it out one coin at a time.
- Coins go to a three-tube hopper (nickel/dime/quarter) over a req/ack handshake.
- The block tracks per-denomination tube inventory, which the supplier refills while the block is idle.
- It reports completion, any unpaid residue, and hopper faults back to the main FSM.

Parameters:
COUNT_W, 6, width of each tube inventory counter (max 63 coins per tube)
TIMEOUT_CYC, 16, cycles disp_req may stay high without hopper_ack before a fault is declared

Ports:
clk  input  1  system clock
hrst  input  1  hard reset, synchronous, active-high
start  input  1  one-cycle pulse: begin paying out balance
balance  input  8  amount to return, in cents (sampled with start)
load_valid  input  1  supplier refill request
load_coin  input  2  coin type to refill (coins_t: 1=NICKEL, 2=DIME, 3=QUARTER, 0=none)
load_count  input  COUNT_W  coins added to that tube
load_ready  output  1  high only in IDLE; a refill is accepted when load_valid && load_ready
busy  output  1  high in every state except IDLE
disp_req  output  1  request hopper to eject one coin
disp_coin  output  2  coins_t of the requested coin, stable while disp_req=1
hopper_ack  input  1  hopper ejected the coin; valid only while disp_req=1
done  output  1  one-cycle pulse at end of a payout
short  output  1  valid with done: change not fully paid
fault  output  1  valid with done: payout ended because of an ack timeout
remaining  output  8  unpaid cents; holds its value after done until the next accepted start
inv_nickel / inv_dime / inv_quarter  output  COUNT_W each  current tube counts

Behaviour:
- One clock, clk. Reset is synchronous and active-high on hrst.
- All outputs are registered.
- Reset values: state=IDLE, inventories=0, remaining=0, disp_req=0, disp_coin=0, done=0, short=0, fault=0, busy=0, load_ready=1.
- hrst asserted mid-payout aborts immediately. No done pulse is produced and inventories clear to 0.
- States:
  - IDLE: load_ready=1.
    - A refill adds load_count to the selected tube, saturating at 2^COUNT_W-1. load_coin=0 is ignored.
    - On start: remaining<=balance, clear short/fault, go to SELECT.
    - If start and load_valid arrive in the same cycle, both are taken; the refill lands first, so the new count is visible in SELECT.
    - A start pulse seen outside IDLE is ignored.
  - SELECT: greedy choice with fallback, evaluated in this order:
    - remaining>=25 and inv_quarter>0 → QUARTER
    - else remaining>=10 and inv_dime>0 → DIME
    - else remaining>=5 and inv_nickel>0 → NICKEL
    - If a coin is chosen: latch disp_coin, clear the timeout counter, go to REQ.
    - If no coin is chosen: go to DONE.
  - REQ: disp_req=1.
    - On hopper_ack: remaining -= coin value (5/10/25), decrement that tube, go to SELECT. disp_req drops the next cycle.
    - Timeout counter increments each REQ cycle without ack. Reaching TIMEOUT_CYC sets fault=1 and goes to DONE; inventory and remaining are not decremented.
  - DONE: done=1 for one cycle, short=(remaining!=0)|fault, then IDLE.
- Latency:
  - start at cycle 0 → disp_req first high at cycle 2.
  - Each further coin costs 2 cycles plus hopper wait.
  - balance=0 → done at cycle 2 with short=0.
- Arithmetic:
  - remaining never underflows, because a coin is only chosen if its value ≤ remaining.
  - A balance that is not a multiple of 5 leaves a 1..4 cent residue, reported as short=1.
- Greedy with fallback is the decided algorithm. Cases it cannot pay despite a feasible combination end short=1; this is accepted, not a bug.
- hopper_ack while disp_req=0 is ignored.

Decomposition:
- Shared package vm2002_common_pkg gets:
  - reuse of the existing coins_t
  - new change_state_t (IDLE, SELECT, REQ, DONE)
  - localparams NICKEL_CENTS=5, DIME_CENTS=10, QUARTER_CENTS=25
  - a coin_value() function mapping coins_t to cents
- One natural sub-module, vm2002_coin_tube. Instantiate it three times. Each instance holds:
  - a saturating add on refill
  - a decrement on dispense
  - a nonzero flag

Test Plan:
1. hrst, refill Q=4, D=4, N=4, start balance=65 → disp_coin sequence QUARTER, QUARTER, DIME, NICKEL (bench acks each 1 cycle after req); done with short=0, remaining=0; inv Q=2, D=3, N=3.
2. Inventory Q=1, D=0, N=2, balance=40 → QUARTER, NICKEL, NICKEL, then done with short=1, remaining=5.
3. balance=0 → done at cycle 2 after start, short=0, disp_req never asserted; balance=7 with N=5 → one NICKEL, done short=1, remaining=2.
4. Bench withholds hopper_ack → disp_req high exactly 16 cycles, then done with fault=1, short=1; inventory unchanged.
5. start and refill during a payout → both ignored (load_ready=0, remaining unaffected); refill N=60 then N=10 in IDLE → inv_nickel=63 (saturated).
6. hrst asserted while disp_req=1 → next cycle busy=0, disp_req=0, all inventories 0, no done pulse.
